// File: rtl/bram_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for bram_fifo_ctrl.
// Signals: wr_valid/wr_ready/wr_data (write side), rd_valid/rd_ready/rd_data
// (read side), count (total entries held by the FIFO).
// master = the user of the FIFO, slave = the FIFO controller.
interface bram_fifo_ctrl_if #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned CNT_W  = 7
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  count;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, count
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, count
  );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller around an external simple-dual-port bram (1-cycle read).
// Port A writes accepted entries, port B prefetches into a 2-entry output
// stage (head + skid) so the consumer can pop one entry per cycle.
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   fifo (slave modport)    : wr_valid/wr_ready/wr_data, rd_valid/rd_ready/rd_data, count
//   bram_wen_a/addr_a/din_a : bram write port
//   bram_wen_b/addr_b/din_b : bram read port controls (write side tied off)
//   bram_dout_b             : bram read data, valid the cycle after the read
module bram_fifo_ctrl #(
  parameter int unsigned NUM_COL    = 16,
  parameter int unsigned COL_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                            clock,
  input  logic                            reset_n,
  bram_fifo_ctrl_if.slave                 fifo,
  output logic [NUM_COL-1:0]              bram_wen_a,
  output logic [ADDR_WIDTH-1:0]           bram_addr_a,
  output logic [NUM_COL*COL_WIDTH-1:0]    bram_din_a,
  output logic [NUM_COL-1:0]              bram_wen_b,
  output logic [ADDR_WIDTH-1:0]           bram_addr_b,
  output logic [NUM_COL*COL_WIDTH-1:0]    bram_din_b,
  input  logic [NUM_COL*COL_WIDTH-1:0]    bram_dout_b
);

  localparam int unsigned W     = NUM_COL * COL_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned CW    = ADDR_WIDTH + 2;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [PW-1:0] mem_cnt_q, mem_cnt_d;
  logic          wr_ready_q, wr_ready_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    held_q,    held_d;
  logic [W-1:0]  head_q,    head_d;
  logic [W-1:0]  skid_q,    skid_d;
  logic [CW-1:0] count_q,   count_d;

  logic          wr_acc;
  logic          pop;
  logic          fetch;
  logic [2:0]    occ;

  // Next-state: pointers, prefetch decision and output-stage shuffling
  always_comb begin
    wr_acc     = fifo.wr_valid && wr_ready_q;
    pop        = (held_q != 2'd0) && fifo.rd_ready;
    occ        = {1'b0, held_q} + {2'b00, inflight_q};
    // Keep at most two entries between the in-flight read and the output stage
    fetch      = (mem_cnt_q != '0) && (occ < (3'd2 + {2'b00, pop}));

    wr_ptr_d   = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d   = rd_ptr_q + PW'(fetch);
    mem_cnt_d  = wr_ptr_d - rd_ptr_d;
    wr_ready_d = mem_cnt_d < DEPTH_P;
    inflight_d = fetch;
    count_d    = count_q + CW'(wr_acc) - CW'(pop);

    head_d     = head_q;
    skid_d     = skid_q;
    held_d     = held_q;
    case (held_q)
      2'd0: begin
        if (inflight_q) begin
          head_d = bram_dout_b;
          held_d = 2'd1;
        end
      end
      2'd1: begin
        if (pop && inflight_q) begin
          head_d = bram_dout_b;
        end else if (pop) begin
          held_d = 2'd0;
        end else if (inflight_q) begin
          skid_d = bram_dout_b;
          held_d = 2'd2;
        end
      end
      default: begin
        // Full stage: a fill can only arrive alongside a pop
        if (pop) begin
          head_d = skid_q;
          if (inflight_q) begin
            skid_d = bram_dout_b;
          end else begin
            held_d = 2'd1;
          end
        end
      end
    endcase
  end

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      wr_ready_q <= 1'b1;
      inflight_q <= 1'b0;
      held_q     <= 2'd0;
      head_q     <= '0;
      skid_q     <= '0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      wr_ready_q <= wr_ready_d;
      inflight_q <= inflight_d;
      held_q     <= held_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      count_q    <= count_d;
    end
  end

  assign fifo.wr_ready = wr_ready_q;
  assign fifo.rd_valid = (held_q != 2'd0);
  assign fifo.rd_data  = head_q;
  assign fifo.count    = count_q;

  // Write port strobes in the handshake cycle itself
  assign bram_wen_a  = wr_acc ? '1 : '0;
  assign bram_addr_a = wr_ptr_q[ADDR_WIDTH-1:0];
  assign bram_din_a  = fifo.wr_data;

  assign bram_wen_b  = '0;
  assign bram_din_b  = '0;
  assign bram_addr_b = rd_ptr_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
module tb_bram_fifo_ctrl;
  localparam int unsigned NUM_COL   = 16;
  localparam int unsigned COL_WIDTH = 32;
  localparam int unsigned AW        = 5;
  localparam int unsigned W         = NUM_COL * COL_WIDTH;
  localparam int unsigned DEPTH     = 2 ** AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bram_fifo_ctrl_if #(.DATA_W(W), .CNT_W(AW + 2)) fif ();

  logic [NUM_COL-1:0] wen_a, wen_b;
  logic [AW-1:0]      addr_a, addr_b;
  logic [W-1:0]       din_a, din_b, dout_b;

  bram_fifo_ctrl #(.NUM_COL(NUM_COL), .COL_WIDTH(COL_WIDTH), .ADDR_WIDTH(AW)) dut (
    .clock       (clk),
    .reset_n     (rst_n),
    .fifo        (fif),
    .bram_wen_a  (wen_a),
    .bram_addr_a (addr_a),
    .bram_din_a  (din_a),
    .bram_wen_b  (wen_b),
    .bram_addr_b (addr_b),
    .bram_din_b  (din_b),
    .bram_dout_b (dout_b)
  );

  // Behavioural bram: byte-column write enables, registered read
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    for (int c = 0; c < int'(NUM_COL); c++)
      if (wen_a[c]) mem[addr_a][c*COL_WIDTH +: COL_WIDTH] <= din_a[c*COL_WIDTH +: COL_WIDTH];
    dout_b <= mem[addr_b];
  end

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] sb [$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v;
    for (int i = 0; i < int'(W / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Mid-cycle sample: stall stability, scoreboard push/pop
  task automatic mid();
    logic [W-1:0] e;
    #4;
    if (prev_stall) chk_w("stall_stable", fif.rd_data, prev_data);
    if (fif.rd_valid && fif.rd_ready) begin
      chk("pop_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk_w("pop_data", fif.rd_data, e);
      end
    end
    if (fif.wr_valid && fif.wr_ready) sb.push_back(fif.wr_data);
    prev_stall = fif.rd_valid && !fif.rd_ready;
    prev_data  = fif.rd_data;
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    mid();
    fin();
  endtask

  initial begin
    logic [W-1:0] pat;
    int n;
    logic acc;

    rst_n        = 1'b0;
    fif.wr_valid = 1'b0;
    fif.wr_data  = '0;
    fif.rd_ready = 1'b0;
    tick();
    mid();
    chk("rst_count",    32'(fif.count),    32'd0);
    chk("rst_rd_valid", 32'(fif.rd_valid), 32'd0);
    chk("rst_wr_ready", 32'(fif.wr_ready), 32'd1);
    chk("rst_wen_a",    32'(wen_a),        32'd0);
    chk("rst_addr_b",   32'(addr_b),       32'd0);
    chk_w("rst_rd_data", fif.rd_data, '0);
    fin();
    rst_n = 1'b1;
    tick();

    // Single write into empty FIFO: visible three cycles later
    pat = {(W/8){8'hA5}};
    fif.wr_valid = 1'b1;
    fif.wr_data  = pat;
    mid();
    chk("c0_wen_a", 32'(wen_a), 32'hFFFF);
    chk("c0_addr_a", 32'(addr_a), 32'd0);
    chk_w("c0_din_a", din_a, pat);
    fin();
    fif.wr_valid = 1'b0;
    mid(); chk("c1_count", 32'(fif.count), 32'd1); chk("c1_rd_valid", 32'(fif.rd_valid), 32'd0); fin();
    mid(); chk("c2_rd_valid", 32'(fif.rd_valid), 32'd0); fin();
    fif.rd_ready = 1'b1;
    mid(); chk("c3_rd_valid", 32'(fif.rd_valid), 32'd1); chk_w("c3_rd_data", fif.rd_data, pat); fin();
    fif.rd_ready = 1'b0;
    mid(); chk("c4_count", 32'(fif.count), 32'd0); chk("c4_rd_valid", 32'(fif.rd_valid), 32'd0); fin();

    // Fill to DEPTH+2; the 35th write must be refused
    for (int i = 0; i < 35; i++) begin
      fif.wr_valid = 1'b1;
      fif.wr_data  = rnd();
      mid();
      if (i == 33) chk("fill_ready_33", 32'(fif.wr_ready), 32'd1);
      if (i == 34) begin
        chk("full_wr_ready", 32'(fif.wr_ready), 32'd0);
        chk("full_count",    32'(fif.count),    32'd34);
        chk("full_wen_a",    32'(wen_a),        32'd0);
      end
      fin();
    end
    fif.wr_valid = 1'b0;
    mid();
    chk("full_count_hold", 32'(fif.count), 32'd34);
    chk("full_sb_size", 32'(sb.size()), 32'd34);
    if (sb.size() != 0) chk_w("full_head", fif.rd_data, sb[0]);
    fin();

    // Drain from full: one pop per cycle, no bubbles
    fif.rd_ready = 1'b1;
    for (int i = 0; i < 34; i++) begin
      mid();
      chk("drain_valid", 32'(fif.rd_valid), 32'd1);
      if (i == 0) chk("drain_wr_ready_0", 32'(fif.wr_ready), 32'd0);
      if (i == 1) chk("drain_wr_ready_1", 32'(fif.wr_ready), 32'd1);
      fin();
    end
    fif.rd_ready = 1'b0;
    mid();
    chk("drain_empty_valid", 32'(fif.rd_valid), 32'd0);
    chk("drain_count", 32'(fif.count), 32'd0);
    chk("drain_sb", 32'(sb.size()), 32'd0);
    fin();

    // Steady state: write and pop every cycle
    for (int i = 0; i < 5; i++) begin
      fif.wr_valid = 1'b1;
      fif.wr_data  = rnd();
      tick();
    end
    fif.wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 100; i++) begin
      fif.wr_valid = 1'b1;
      fif.wr_data  = rnd();
      fif.rd_ready = 1'b1;
      mid();
      chk("steady_count", 32'(fif.count), 32'd5);
      chk("steady_valid", 32'(fif.rd_valid), 32'd1);
      fin();
    end
    fif.wr_valid = 1'b0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    fif.rd_ready = 1'b0;
    mid();
    chk("steady_drained", 32'(sb.size()), 32'd0);
    chk("steady_count_end", 32'(fif.count), 32'd0);
    fin();

    // Random back-pressure over a 64-entry stream (crosses pointer wrap)
    n = 0;
    fif.wr_valid = 1'b1;
    fif.wr_data  = rnd();
    for (int k = 0; k < 600 && n < 64; k++) begin
      fif.rd_ready = 1'($urandom_range(0, 1));
      mid();
      acc = fif.wr_valid && fif.wr_ready;
      fin();
      if (acc) begin
        n++;
        if (n < 64) fif.wr_data = rnd();
        else fif.wr_valid = 1'b0;
      end
    end
    fif.wr_valid = 1'b0;
    chk("rand_all_written", 32'(n), 32'd64);
    for (int k = 0; k < 200 && sb.size() != 0; k++) begin
      fif.rd_ready = 1'($urandom_range(0, 1));
      tick();
    end
    fif.rd_ready = 1'b0;
    mid();
    chk("rand_drained", 32'(sb.size()), 32'd0);
    chk("rand_count_end", 32'(fif.count), 32'd0);
    fin();

    // Mid-operation reset with 10 entries held
    for (int i = 0; i < 10; i++) begin
      fif.wr_valid = 1'b1;
      fif.wr_data  = rnd();
      tick();
    end
    fif.wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    mid();
    chk("pre_rst_count", 32'(fif.count), 32'd10);
    chk("pre_rst_valid", 32'(fif.rd_valid), 32'd1);
    fin();
    rst_n = 1'b0;
    sb.delete();
    prev_stall = 1'b0;
    mid();
    chk("mid_rst_count",    32'(fif.count),    32'd0);
    chk("mid_rst_valid",    32'(fif.rd_valid), 32'd0);
    chk("mid_rst_wr_ready", 32'(fif.wr_ready), 32'd1);
    chk_w("mid_rst_data", fif.rd_data, '0);
    fin();
    rst_n = 1'b1;
    pat = {(W/8){8'h3C}};
    fif.wr_valid = 1'b1;
    fif.wr_data  = pat;
    tick();
    fif.wr_valid = 1'b0;
    mid(); chk("post_rst_c1_valid", 32'(fif.rd_valid), 32'd0); fin();
    mid(); chk("post_rst_c2_valid", 32'(fif.rd_valid), 32'd0); fin();
    fif.rd_ready = 1'b1;
    mid(); chk("post_rst_c3_valid", 32'(fif.rd_valid), 32'd1); chk_w("post_rst_data", fif.rd_data, pat); fin();
    fif.rd_ready = 1'b0;
    mid(); chk("post_rst_count", 32'(fif.count), 32'd0); chk("post_rst_sb", 32'(sb.size()), 32'd0); fin();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
